// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cpu_pkg                                                          |
// | Purpose : Shared constants and types for the CPU front end: reset PC,      |
// |           instruction width, imem word-address width, fetch-entry record   |
// |           and fetch FSM state encoding.                                    |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  localparam int          INST_W       = 32;
  localparam int          IMEM_ADDR_W  = 11;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fetch_queue2                                                     |
// | Purpose : 2-entry synchronous FIFO of fetch entries. Entry 0 is always the |
// |           head, so the head output comes straight from a register.         |
// | Ports   : clk, rst        - clock, async active-high reset                 |
// |           i_push/i_data   - write a new entry at the tail                  |
// |           i_pop           - remove the head entry                          |
// |           i_flush         - empty the queue (wins over push and pop)       |
// |           o_head          - head entry                                     |
// |           o_count/o_full/o_empty - occupancy                               |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module fetch_queue2
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_data,
  input  logic               i_pop,
  input  logic               i_flush,
  output logic [ENTRY_W-1:0] o_head,
  output logic [1:0]         o_count,
  output logic               o_full,
  output logic               o_empty
);

  logic [ENTRY_W-1:0] r_mem0;
  logic [ENTRY_W-1:0] r_mem1;
  logic [1:0]         r_count;
  logic               w_pop;
  logic               w_push;

  // Pop of an empty queue is ignored; push into a full queue only lands when
  // the head leaves in the same cycle.
  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem0  <= '0;
      r_mem1  <= '0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_mem0 <= i_data;
          else                 r_mem1 <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_mem0  <= r_mem1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: occupancy unchanged, contents shift by one.
          if (r_count == 2'd1) begin
            r_mem0 <= i_data;
          end else begin
            r_mem0 <= r_mem1;
            r_mem1 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head  = r_mem0;
  assign o_count = r_count;
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);

endmodule
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : inst_fetch_unit                                                  |
// | Purpose : Instruction fetch front end. Owns the PC, addresses the async    |
// |           instruction ROM, queues fetched words in a 2-entry FIFO and      |
// |           presents them to decode with valid/ready. Handles redirects and  |
// |           a sticky fault for misaligned / out-of-window PCs.               |
// | Ports   : clk, rst                 - clock, async active-high reset        |
// |           imem_addr / imem_inst    - ROM word address / read data          |
// |           redirect_valid/_pc       - PC change request from execute        |
// |           id_ready / id_valid      - decode handshake                      |
// |           id_inst / id_pc          - head instruction and its byte address |
// |           fetch_fault              - sticky fetch fault flag               |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          ADDR_W   = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_inst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [31:0]       id_inst,
  output logic [31:0]       id_pc,
  output logic              fetch_fault
);

  localparam logic [31:0] WIN_BYTES = 32'd4 << ADDR_W;

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;

  logic [31:0]  w_off;
  logic [31:0]  w_roff;
  logic         w_pc_ok;
  logic         w_redir_ok;
  logic         w_pop;
  logic         w_fetch_try;
  logic         w_push;

  fetch_entry_t w_push_data;
  fetch_entry_t w_head;
  logic [1:0]   w_count;
  logic         w_full;
  logic         w_empty;

  // Offsets are 32-bit wrapping, so PCs below RESET_PC land far above the
  // window and fail the range check without a separate lower-bound test.
  assign w_off      = r_pc - RESET_PC;
  assign w_roff     = redirect_pc - RESET_PC;
  assign w_pc_ok    = (w_off[1:0] == 2'b00) && (w_off < WIN_BYTES);
  assign w_redir_ok = (w_roff[1:0] == 2'b00) && (w_roff < WIN_BYTES);
  assign imem_addr  = w_off[ADDR_W+1:2];

  assign w_pop       = id_ready && !w_empty;
  assign w_fetch_try = (r_state == ST_RUN) && !redirect_valid && (!w_full || w_pop);
  assign w_push      = w_fetch_try && w_pc_ok;

  assign w_push_data = '{pc: r_pc, inst: imem_inst};

  // Redirect drives flush, which the queue treats as higher priority than
  // both push and pop, so a coinciding handshake is dropped.
  fetch_queue2 u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      ST_RUN: begin
        if (redirect_valid) begin
          // An out-of-range target is caught by the next fetch attempt.
          w_pc_nxt = redirect_pc;
        end else if (w_fetch_try) begin
          if (w_pc_ok) w_pc_nxt    = r_pc + 32'd4;
          else         w_state_nxt = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (redirect_valid) begin
          w_pc_nxt = redirect_pc;
          if (w_redir_ok) w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign id_valid    = (w_count != 2'd0);
  assign id_inst     = w_head.inst;
  assign id_pc       = w_head.pc;
  assign fetch_fault = (r_state == ST_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_inst_fetch_unit                                               |
// | Purpose : Self-checking bench for inst_fetch_unit. ROM word k holds        |
// |           32'h1000_0000 + k. Directed per-cycle vectors plus a hand        |
// |           sequence for the asynchronous reset.                             |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic [10:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        fetch_fault;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic [10:0] eaddr;
    logic        ef;
  } vec_t;

  vec_t vq[$];

  inst_fetch_unit #(
    .RESET_PC (32'h0040_0000),
    .ADDR_W   (11)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .fetch_fault    (fetch_fault)
  );

  // Asynchronous-read ROM model.
  assign imem_inst = 32'h1000_0000 + {21'd0, imem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input int k);
    return 32'h1000_0000 + 32'(k);
  endfunction

  function automatic void add(input logic rv, input logic [31:0] rpc, input logic rdy,
                              input logic ev, input logic [31:0] epc, input int k,
                              input int eaddr, input logic ef);
    vec_t v;
    v.rv    = rv;
    v.rpc   = rpc;
    v.rdy   = rdy;
    v.ev    = ev;
    v.epc   = epc;
    v.einst = word(k);
    v.eaddr = 11'(eaddr);
    v.ef    = ef;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    id_ready       = 1'b0;

    // rv, rpc, rdy | ev, epc, word, imem_addr, fault  (checked after the edge)
    // Stall right after reset: queue fills to 2 and PC parks at word 2.
    add(0, 0, 0,  1, 32'h0040_0000, 0, 1, 0);
    add(0, 0, 0,  1, 32'h0040_0000, 0, 2, 0);
    add(0, 0, 0,  1, 32'h0040_0000, 0, 2, 0);
    add(0, 0, 0,  1, 32'h0040_0000, 0, 2, 0);
    add(0, 0, 0,  1, 32'h0040_0000, 0, 2, 0);
    // Release: words 1,2,3 reach the head in order, full queue keeps fetching.
    add(0, 0, 1,  1, 32'h0040_0004, 1, 3, 0);
    add(0, 0, 1,  1, 32'h0040_0008, 2, 4, 0);
    add(0, 0, 1,  1, 32'h0040_000C, 3, 5, 0);
    // Redirect with full queue and a coinciding handshake.
    add(1, 32'h0040_0100, 1,  0, 0, 0, 64, 0);
    add(0, 0, 1,  1, 32'h0040_0100, 64, 65, 0);
    add(0, 0, 1,  1, 32'h0040_0104, 65, 66, 0);
    // Misaligned redirect -> fault, then recovery at word 0.
    add(1, 32'h0040_0102, 1,  0, 0, 0, 64, 0);
    add(0, 0, 1,  0, 0, 0, 64, 1);
    add(0, 0, 1,  0, 0, 0, 64, 1);
    add(1, 32'h0040_0000, 1,  0, 0, 0, 0, 0);
    add(0, 0, 1,  1, 32'h0040_0000, 0, 1, 0);
    // Walk off the end of the window.
    add(1, 32'h0040_1FF8, 1,  0, 0, 0, 2046, 0);
    add(0, 0, 0,  1, 32'h0040_1FF8, 2046, 2047, 0);
    add(0, 0, 0,  1, 32'h0040_1FF8, 2046, 0, 0);
    add(0, 0, 0,  1, 32'h0040_1FF8, 2046, 0, 0);
    add(0, 0, 1,  1, 32'h0040_1FFC, 2047, 0, 1);
    add(0, 0, 1,  0, 0, 0, 0, 1);
    add(0, 0, 1,  0, 0, 0, 0, 1);
    // Out-of-range redirect while faulted: PC loads, fault stays.
    add(1, 32'h0050_0010, 1,  0, 0, 0, 4, 1);
    add(0, 0, 1,  0, 0, 0, 4, 1);
    // In-range redirect clears the fault.
    add(1, 32'h0040_0008, 1,  0, 0, 0, 2, 0);
    add(0, 0, 1,  1, 32'h0040_0008, 2, 3, 0);
    add(0, 0, 0,  1, 32'h0040_0008, 2, 4, 0);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset id_valid",    32'(id_valid),    32'd0);
    check("reset id_pc",       id_pc,            32'd0);
    check("reset id_inst",     id_inst,          32'd0);
    check("reset fetch_fault", 32'(fetch_fault), 32'd0);
    check("reset imem_addr",   32'(imem_addr),   32'd0);

    foreach (vq[i]) begin
      redirect_valid = vq[i].rv;
      redirect_pc    = vq[i].rpc;
      id_ready       = vq[i].rdy;
      tick();
      check($sformatf("row%0d id_valid", i),    32'(id_valid),    32'(vq[i].ev));
      check($sformatf("row%0d imem_addr", i),   32'(imem_addr),   32'(vq[i].eaddr));
      check($sformatf("row%0d fetch_fault", i), 32'(fetch_fault), 32'(vq[i].ef));
      if (vq[i].ev) begin
        check($sformatf("row%0d id_pc", i),   id_pc,   vq[i].epc);
        check($sformatf("row%0d id_inst", i), id_inst, vq[i].einst);
      end
    end

    // Queue is full here; reset must clear outputs without a clock edge.
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async rst id_valid",    32'(id_valid),    32'd0);
    check("async rst id_pc",       id_pc,            32'd0);
    check("async rst id_inst",     id_inst,          32'd0);
    check("async rst fetch_fault", 32'(fetch_fault), 32'd0);
    check("async rst imem_addr",   32'(imem_addr),   32'd0);
    #1;
    rst      = 1'b0;
    id_ready = 1'b1;
    tick();
    check("restart id_valid",  32'(id_valid),  32'd1);
    check("restart id_pc",     id_pc,          32'h0040_0000);
    check("restart id_inst",   id_inst,        word(0));
    check("restart imem_addr", 32'(imem_addr), 32'd1);
    tick();
    check("restart2 id_pc",    id_pc,          32'h0040_0004);
    check("restart2 id_inst",  id_inst,        word(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
